// File: rtl/apb_ctrl_pkg.sv
// Shared types and defaults for the APB master/arbiter slice.
package apb_ctrl_pkg;

    localparam int unsigned APB_AW = 8;
    localparam int unsigned APB_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RDWAIT
    } apb_state_t;

    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
        logic              write;
    } apb_xfer_t;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin grant selection; the pointer register is owned by the parent.
module apb_rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       pointer,
    output logic       grant_valid,
    output logic       grant_id
);

    // Single eligible requester wins outright; on contention the pointer decides.
    always_comb begin
        grant_valid = |eligible;
        if (eligible == 2'b11) begin
            grant_id = pointer;
        end else begin
            grant_id = eligible[1];
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters with round-robin arbitration,
// pready wait handling, optional time-out and optional read-data latency.
module apb_master_arb
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned AW        = APB_AW,
    parameter int unsigned DW        = APB_DW,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned RDATA_LAT = 1
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic [1:0]    req,
    input  logic [1:0]    req_write,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    output logic [1:0]    done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic          pready,
    input  logic [DW-1:0] prdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_t    state, state_nxt;
    logic          ptr, ptr_nxt;
    logic          id, id_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          timeout_hit;
    logic [1:0]    eligible;
    logic          gvalid, gid;

    logic          psel_nxt, penable_nxt, pwrite_nxt, err_nxt;
    logic [AW-1:0] paddr_nxt;
    logic [DW-1:0] pwdata_nxt, rdata_nxt;
    logic [1:0]    done_nxt;

    // A requester seeing its own done pulse is not eligible that cycle.
    assign eligible    = req & ~done;
    assign cnt_inc     = cnt + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    apb_rr_arb2 u_arb (
        .eligible    (eligible),
        .pointer     (ptr),
        .grant_valid (gvalid),
        .grant_id    (gid)
    );

    // State and registered-output update with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            id      <= 1'b0;
            cnt     <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            done    <= '0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            id      <= id_nxt;
            cnt     <= cnt_nxt;
            psel    <= psel_nxt;
            penable <= penable_nxt;
            pwrite  <= pwrite_nxt;
            paddr   <= paddr_nxt;
            pwdata  <= pwdata_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            rdata   <= rdata_nxt;
        end
    end

    // Next-state selection for the transfer sequencer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (gvalid) state_nxt = SETUP;
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_nxt = ((RDATA_LAT != 0) && !pwrite) ? RDWAIT : IDLE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            RDWAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered APB outputs, completion signals and bookkeeping.
    always_comb begin
        psel_nxt    = psel;
        penable_nxt = penable;
        pwrite_nxt  = pwrite;
        paddr_nxt   = paddr;
        pwdata_nxt  = pwdata;
        rdata_nxt   = rdata;
        done_nxt    = '0;
        err_nxt     = 1'b0;
        id_nxt      = id;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        unique case (state)
            IDLE: begin
                if (gvalid) begin
                    id_nxt      = gid;
                    paddr_nxt   = gid ? req_addr1 : req_addr0;
                    pwdata_nxt  = gid ? req_wdata1 : req_wdata0;
                    pwrite_nxt  = req_write[gid];
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    cnt_nxt     = '0;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    if ((RDATA_LAT == 0) || pwrite) begin
                        done_nxt[id] = 1'b1;
                        rdata_nxt    = pwrite ? '0 : prdata;
                        ptr_nxt      = ~id;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    if (timeout_hit) begin
                        psel_nxt     = 1'b0;
                        penable_nxt  = 1'b0;
                        done_nxt[id] = 1'b1;
                        err_nxt      = 1'b1;
                        rdata_nxt    = '0;
                        ptr_nxt      = ~id;
                    end
                end
            end
            RDWAIT: begin
                done_nxt[id] = 1'b1;
                rdata_nxt    = prdata;
                ptr_nxt      = ~id;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Two-requester APB master that shares one APB bus between two internal requesters.
- Round-robin arbitration; sequences each transfer through the APB SETUP and ACCESS phases.
- Waits on pready, with an optional time-out, and returns read data and a completion pulse to the granted requester.
- Sits between on-chip requesters (CPU-side glue, test sequencer) and the team's APB slaves, e.g. the 64x8 register memory.

Parameters:
- AW, 8, APB address width.
- DW, 8, APB data width.
- TIMEOUT, 16, consecutive ACCESS cycles with pready low before abort; 0 disables the time-out.
- RDATA_LAT, 1, extra cycles after the ACCESS phase before prdata is sampled (0 or 1); 1 suits slaves that register prdata on the access edge.

Ports:
- pclk  in  1  clock.
- preset  in  1  synchronous active-high reset.
- req  in  2  per-requester transfer request.
- req_write  in  2  per-requester direction, 1 = write.
- req_addr0 / req_addr1  in  AW each  addresses.
- req_wdata0 / req_wdata1  in  DW each  write data.
- done  out  2  one-cycle completion pulse per requester.
- err  out  1  valid with done; 1 = time-out abort.
- rdata  out  DW  read result, valid with done.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- pready  in  1  slave ready.
- prdata  in  DW  slave read data.

Behaviour:
- Clock and reset: one clock, pclk. Reset is synchronous and active-high (preset); polarity and synchronicity are fixed.
- Registered outputs: all outputs are registered.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, done=0, err=0, rdata=0, FSM=IDLE, priority pointer = requester 0, timeout counter=0.
- Reset mid-transfer: abandons the transfer at the next edge; no done pulse is issued.
- FSM states: IDLE, SETUP, ACCESS, RDWAIT.
- IDLE:
  - Eligible requester: req[i]=1 and done[i]=0 in the same cycle, so a requester still holding req during its own done pulse is not re-granted.
  - One eligible requester is granted. Two eligible: the pointer picks.
  - At the edge, latch id, addr, wdata and write into paddr/pwdata/pwrite; go SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - pready=1 and (RDATA_LAT=0 or write): at the edge, psel=penable=0, done[id]=1, err=0; rdata=prdata for a read, 0 for a write; go IDLE.
  - pready=1, read, RDATA_LAT=1: psel=penable=0, go RDWAIT.
  - pready=0: increment the counter. When TIMEOUT!=0 and the counter reaches TIMEOUT, drop psel/penable, set done[id]=1, err=1, rdata=0, go IDLE.
- RDWAIT: one cycle; at the edge rdata=prdata, done[id]=1, go IDLE.
- Pulses: done and err last exactly one cycle; done is never asserted for both requesters at once.
- Pointer update: on every completion (including a time-out), the pointer moves to the requester not just served.
- Latency with a zero-wait slave, from req sampled in IDLE to done high:
  - write, or read with RDATA_LAT=0: 3 cycles;
  - read with RDATA_LAT=1: 4 cycles.
- Minimum one IDLE cycle between transfers.
- Request fields are sampled only at grant; later changes are ignored until the next grant.
- Counter clears on entry to SETUP.

Decomposition:
- Shared package apb_ctrl_pkg:
  - state enum (IDLE, SETUP, ACCESS, RDWAIT);
  - APB_AW/APB_DW default constants;
  - a transfer struct (addr, wdata, write).
- Sub-module apb_rr_arb2: 2-way round-robin arbiter.
  - Inputs: eligible[1:0], pointer.
  - Outputs: grant_valid, grant_id.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Write: req[0]=1, write, addr=0x05, wdata=0xA5, zero-wait slave -> psel rises 1 cycle later, penable 2 cycles later; paddr=0x05, pwdata=0xA5; done[0] pulses at cycle 3, err=0.
- Read-back with registered-read slave, RDATA_LAT=1: req[0] read addr=0x05 -> done[0] at cycle 4, rdata=0xA5.
- Contention: req=2'b11 from reset, both writes (addr 0x10, 0x20) -> requester 0 served first, then requester 1. Repeat with both held -> grants alternate 0,1,0,1; no back-to-back done on one id.
- Wait states: slave holds pready low 3 ACCESS cycles -> psel/penable/paddr stable throughout; done one cycle after pready rises, err=0.
- Time-out: TIMEOUT=4, pready stuck low -> after 4 ACCESS cycles psel=penable=0, done[id]=1, err=1, rdata=0; next request proceeds normally.
- Reset mid-op: assert preset for one cycle during ACCESS -> next cycle all outputs at reset values, no done, pointer back to requester 0.
